// File: rtl/breakout_frame_sched.sv
// Per-frame scheduler for the breakout datapath: sequences paddle, ball, collision
// and brick erase on each PLAY frame, and owns the brick/lives counters and win/lose pulses.
module breakout_frame_sched #(
  parameter int BRICK_NUM = 40,
  parameter int IDX_W     = 6,
  parameter int LIVES     = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [1:0]       game_state,
  input  logic             game_reset,
  input  logic             frame_tick,
  output logic             paddle_upd,
  output logic             ball_upd,
  output logic             coll_start,
  input  logic             coll_done,
  input  logic             coll_hit,
  input  logic [IDX_W-1:0] coll_idx,
  input  logic             coll_miss,
  output logic             brick_we,
  output logic [IDX_W-1:0] brick_waddr,
  output logic             ball_serve,
  output logic             win_sig,
  output logic             lose_sig,
  output logic [1:0]       lives,
  output logic [5:0]       bricks_left,
  output logic             frame_overrun
);

  localparam logic [1:0]       ST_PLAY     = 2'b01;
  localparam logic [5:0]       BRICKS_INIT = 6'(BRICK_NUM);
  localparam logic [1:0]       LIVES_INIT  = 2'(LIVES);
  localparam logic [IDX_W:0]   BRICK_LIM   = (IDX_W+1)'(BRICK_NUM);

  typedef enum logic [2:0] {
    S_WAIT, S_PADDLE, S_BALL, S_COLL, S_BRICK, S_CHECK
  } state_t;

  state_t           r_state;
  logic             r_paddle_upd, r_ball_upd, r_coll_start, r_brick_we;
  logic             r_ball_serve, r_win_sig, r_lose_sig;
  logic [IDX_W-1:0] r_brick_waddr;
  logic [1:0]       r_lives;
  logic [5:0]       r_bricks;
  logic             r_overrun;
  logic             r_miss;

  logic             w_idx_ok;
  logic [5:0]       w_bricks_dec;
  logic [5:0]       w_chk_bricks;
  logic             w_chk_miss;
  logic             w_win, w_lose, w_serve;

  assign w_idx_ok     = ({1'b0, coll_idx} < BRICK_LIM);
  assign w_bricks_dec = (r_bricks == 6'd0) ? 6'd0 : r_bricks - 6'd1;

  // The check outcome is registered on entry to S_CHECK, so it must look at the
  // post-erase brick count and at the miss bit being latched in the same edge.
  assign w_chk_bricks = (r_state == S_BRICK) ? w_bricks_dec : r_bricks;
  assign w_chk_miss   = (r_state == S_BRICK) ? r_miss : coll_miss;
  assign w_win        = (w_chk_bricks == 6'd0);
  assign w_lose       = !w_win && w_chk_miss && (r_lives == 2'd1);
  assign w_serve      = !w_win && w_chk_miss && (r_lives > 2'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= S_WAIT;
      r_paddle_upd  <= 1'b0;
      r_ball_upd    <= 1'b0;
      r_coll_start  <= 1'b0;
      r_brick_we    <= 1'b0;
      r_ball_serve  <= 1'b0;
      r_win_sig     <= 1'b0;
      r_lose_sig    <= 1'b0;
      r_brick_waddr <= '0;
      r_lives       <= LIVES_INIT;
      r_bricks      <= BRICKS_INIT;
      r_overrun     <= 1'b0;
      r_miss        <= 1'b0;
    end else begin
      r_paddle_upd <= 1'b0;
      r_ball_upd   <= 1'b0;
      r_coll_start <= 1'b0;
      r_brick_we   <= 1'b0;
      r_ball_serve <= 1'b0;
      r_win_sig    <= 1'b0;
      r_lose_sig   <= 1'b0;
      if (game_reset) begin
        r_state   <= S_WAIT;
        r_lives   <= LIVES_INIT;
        r_bricks  <= BRICKS_INIT;
        r_overrun <= 1'b0;
        r_miss    <= 1'b0;
      end else begin
        if (frame_tick && (r_state != S_WAIT))
          r_overrun <= 1'b1;
        if ((r_state != S_WAIT) && (game_state != ST_PLAY)) begin
          r_state <= S_WAIT;
        end else begin
          case (r_state)
            S_WAIT: begin
              if (frame_tick && (game_state == ST_PLAY)) begin
                r_state      <= S_PADDLE;
                r_paddle_upd <= 1'b1;
              end
            end
            S_PADDLE: begin
              r_state    <= S_BALL;
              r_ball_upd <= 1'b1;
            end
            S_BALL: begin
              r_state      <= S_COLL;
              r_coll_start <= 1'b1;
            end
            S_COLL: begin
              if (coll_done) begin
                r_brick_waddr <= coll_idx;
                r_miss        <= coll_miss;
                if (coll_hit && w_idx_ok) begin
                  r_state    <= S_BRICK;
                  r_brick_we <= (r_bricks != 6'd0);
                end else begin
                  r_state      <= S_CHECK;
                  r_win_sig    <= w_win;
                  r_lose_sig   <= w_lose;
                  r_ball_serve <= w_serve;
                end
              end
            end
            S_BRICK: begin
              r_bricks     <= w_bricks_dec;
              r_state      <= S_CHECK;
              r_win_sig    <= w_win;
              r_lose_sig   <= w_lose;
              r_ball_serve <= w_serve;
            end
            S_CHECK: begin
              if (r_lose_sig)
                r_lives <= 2'd0;
              else if (r_ball_serve)
                r_lives <= r_lives - 2'd1;
              r_state <= S_WAIT;
            end
            default: r_state <= S_WAIT;
          endcase
        end
      end
    end
  end

  // A game_reset cycle must not leak any strobe already registered.
  assign paddle_upd    = r_paddle_upd & ~game_reset;
  assign ball_upd      = r_ball_upd   & ~game_reset;
  assign coll_start    = r_coll_start & ~game_reset;
  assign brick_we      = r_brick_we   & ~game_reset;
  assign ball_serve    = r_ball_serve & ~game_reset;
  assign win_sig       = r_win_sig    & ~game_reset;
  assign lose_sig      = r_lose_sig   & ~game_reset;
  assign brick_waddr   = r_brick_waddr;
  assign lives         = r_lives;
  assign bricks_left   = r_bricks;
  assign frame_overrun = r_overrun;

endmodule

// File: doc/breakout_frame_sched.md
# breakout_frame_sched

Per-frame scheduler for the breakout game datapath. On every frame tick while the game FSM is in PLAY, it sequences paddle update, ball update, collision check and brick-RAM erase in fixed order. It owns the brick and lives counters and generates the `win_sig` / `lose_sig` pulses consumed by `breakout_fsm`. It sits between the VGA timing block (frame tick), `breakout_fsm` (`game_state` / `game_reset`) and the paddle, ball, collision and brick-RAM units.

## Interface
- `BRICK_NUM`, 40: bricks on a fresh board.
- `IDX_W`, 6: brick index / RAM address width; must satisfy `2^IDX_W >= BRICK_NUM`.
- `LIVES`, 3: lives per game, range 1..3.
- `sys_clk` in 1: 50 MHz system clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `game_state` in 2: FSM state; 00 IDLE, 01 PLAY, 10 WIN, 11 END.
- `game_reset` in 1: one-cycle pulse from FSM on entry to PLAY.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `paddle_upd` out 1: one-cycle strobe; paddle unit latches new position.
- `ball_upd` out 1: one-cycle strobe; ball unit advances position.
- `coll_start` out 1: one-cycle strobe; collision unit begins check.
- `coll_done` in 1: one-cycle pulse; collision result valid.
- `coll_hit` in 1: brick hit; valid with `coll_done`.
- `coll_idx` in `IDX_W`: index of the hit brick; valid with `coll_done`.
- `coll_miss` in 1: ball passed the paddle; valid with `coll_done`.
- `brick_we` out 1: brick-RAM write enable; writes 0 (erased).
- `brick_waddr` out `IDX_W`: brick-RAM address.
- `ball_serve` out 1: one-cycle pulse; re-serve ball after a lost life.
- `win_sig` out 1: one-cycle pulse; last brick erased.
- `lose_sig` out 1: one-cycle pulse; last life lost.
- `lives` out 2: remaining lives.
- `bricks_left` out 6: remaining bricks.
- `frame_overrun` out 1: sticky flag; a `frame_tick` arrived while busy.

## Operation
- States:
  - S_WAIT → S_PADDLE on `frame_tick` while `game_state == 01`; otherwise remain in S_WAIT.
  - S_PADDLE → S_BALL unconditionally.
  - S_BALL → S_COLL unconditionally.
  - S_COLL: wait for `coll_done`. If `coll_hit` is set and `coll_idx < BRICK_NUM` → S_BRICK; else → S_CHECK.
  - S_BRICK → S_CHECK unconditionally.
  - S_CHECK → S_WAIT unconditionally.
- Strobes are decoded from state, one cycle each:
  - `paddle_upd` in S_PADDLE.
  - `ball_upd` in S_BALL.
  - `coll_start` in the first cycle of S_COLL only.
  - `brick_we` in S_BRICK.
- On `coll_done`, latch `coll_idx` into `brick_waddr` and latch `coll_miss` into an internal miss flag.
- S_BRICK: `bricks_left` decrements by 1. Saturate at 0; with `bricks_left == 0`, suppress both the write and the decrement.
- S_CHECK evaluation (hit and miss in the same result: the hit is processed first, then the miss):
  - `bricks_left == 0` → `win_sig`. The miss flag is ignored and lives are unchanged.
  - Else if miss flag and `lives == 1` → `lose_sig`; `lives` becomes 0.
  - Else if miss flag → `ball_serve`; `lives` decrements by 1.
- `game_reset` has priority over all other activity:
  - reload `bricks_left = BRICK_NUM` and `lives = LIVES`;
  - clear `frame_overrun` and the miss flag;
  - force S_WAIT;
  - suppress all strobes in that cycle.
- If `game_state` leaves 01 while in any state other than S_WAIT: go to S_WAIT next cycle. No further strobes, counter changes or win/lose pulses occur.
- A `frame_tick` arriving outside S_WAIT sets `frame_overrun` and is dropped. It is not queued.
- `coll_done` seen outside S_COLL is ignored.

## Timing
- Reset values (async): state S_WAIT; all strobes 0; `brick_waddr = 0`; `lives = LIVES`; `bricks_left = BRICK_NUM`; `frame_overrun = 0`.
- Sequence from `frame_tick` sampled high at edge T:
  - `paddle_upd` high in cycle T+1.
  - `ball_upd` high in T+2.
  - `coll_start` high in T+3.
- Sequence from `coll_done` sampled at edge C:
  - Hit case: `brick_we` in C+1; S_CHECK pulses in C+2; back in S_WAIT at C+3.
  - No-hit case: S_CHECK pulses in C+1; back in S_WAIT at C+2.
- Fastest case: `coll_done` in the same cycle as `coll_start` (C = T+3).
- Counters update on the clock edge ending S_BRICK / S_CHECK. S_CHECK sees the already-decremented `bricks_left`.
- `win_sig`, `lose_sig` and `ball_serve` are mutually exclusive. Each lasts exactly 1 cycle.

## Test plan
- Reset, `game_state = 01`, `frame_tick` at T, `coll_done` at T+3 with no hit/miss:
  - `paddle_upd`, `ball_upd`, `coll_start` at T+1/T+2/T+3;
  - no `brick_we`; idle at T+5.
- Hit idx 7 with `bricks_left = 40`:
  - `brick_we = 1`, `brick_waddr = 7` for one cycle;
  - `bricks_left = 39`; no `win_sig`.
- `BRICK_NUM` hits:
  - `win_sig` exactly once on the final frame; `bricks_left = 0`;
  - a hit with idx 45 produces no write.
- `LIVES` misses:
  - `ball_serve` on misses 1–2, `lose_sig` on miss 3, `lives = 0`;
  - hit+miss on the last brick gives `win_sig` only.
- Drop `game_state` to 11 while waiting in S_COLL:
  - later `coll_done` ignored; no strobes; state S_WAIT.
- `frame_tick` at T+2 (busy):
  - `frame_overrun = 1` and no second sequence;
  - `game_reset` clears the flag and reloads 40/3.
